// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU stage (producer), the result queue and its consumer.
interface alu_result_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_flags;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, in_data, in_flags, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_flags, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/alu_result_queue.sv
// FIFO of ALU results with committed NZCV status register; NOP results are dropped.
// Optional sticky overflow tracking is enabled by defining ALU_STICKY_OVF_EN.
module alu_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_queue_if.slave   bus,
    output logic [3:0]          status_flags,
    output logic [3:0]          count,
    output logic                sticky_ovf,
    input  logic                clr_sticky
);
    localparam int PW = $clog2(DEPTH);

    logic [35:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy, so a full queue refuses even while popping.
    assign bus.in_ready  = (count < 4'(DEPTH));
    assign bus.out_valid = (count != 4'd0);
    assign push = bus.in_valid & bus.in_ready & (bus.in_ctrl != 3'b000);
    assign pop  = bus.out_valid & bus.out_ready;
    assign {bus.out_flags, bus.out_data} = bus.out_valid ? mem[rptr] : 36'd0;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {bus.in_flags, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= 4'd0;
            wptr         <= '0;
            rptr         <= '0;
            status_flags <= 4'd0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop) begin
                rptr         <= nxt(rptr);
                status_flags <= bus.out_flags;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_STICKY_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                      sticky_ovf <= 1'b0;
        else if (pop && bus.out_flags[0]) sticky_ovf <= 1'b1;
        else if (clr_sticky)             sticky_ovf <= 1'b0;
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_ovf = 1'b0;
`endif
endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-queue entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port in_valid  input  1  producer (ALU stage) presents a result.
REQ-005 SHALL have port in_ready  output  1  queue can accept a result this cycle.
REQ-006 SHALL have port in_data  input  32  ALU dataOut.
REQ-007 SHALL have port in_flags  input  4  ALU flags {negative, zero, carryout, overflow} at bits [3:0].
REQ-008 SHALL have port in_ctrl  input  3  ALU control code of the result (000 = NOP).
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port out_data  output  32  head entry data.
REQ-012 SHALL have port out_flags  output  4  head entry flags, same bit order as in_flags.
REQ-013 SHALL have port status_flags  output  4  committed NZCV status register.
REQ-014 SHALL have port count  output  4  number of occupied entries, 0..DEPTH.
REQ-015 SHALL have port sticky_ovf  output  1  sticky overflow indicator.
REQ-016 SHALL have port clr_sticky  input  1  clears sticky_ovf.

Function
REQ-017 SHALL push when in_valid and in_ready are both high at a clk edge; SHALL pop when out_valid and out_ready are both high.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinationally from registered state only; no dependence on out_ready.
REQ-019 SHALL drive out_valid = (count != 0); out_data/out_flags SHALL show the oldest entry, stable while out_valid is high and no pop occurs.
REQ-020 SHALL have latency of exactly one cycle: an entry pushed at edge N is visible at the outputs after edge N; no combinational bypass.
REQ-021 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-022 SHALL, when full, refuse pushes (in_ready low) even if a pop occurs in the same cycle.
REQ-023 SHALL ignore out_ready when empty and in_valid when full; count SHALL never underflow or exceed DEPTH.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL discard NOP results: a push with in_ctrl = 000 SHALL complete the handshake but not occupy an entry.
REQ-026 SHALL update status_flags with out_flags on each pop; status_flags SHALL hold otherwise.
REQ-027 SHALL drive out_data/out_flags to zero when empty.

Reset
REQ-028 SHALL, when rst_n is low at a clk edge, clear count, both pointers, status_flags and sticky_ovf to 0, regardless of pending handshakes.
REQ-029 SHALL, during and after reset, give out_valid = 0, in_ready = 1 (with rst_n high), out_data = 0 and out_flags = 0; entries in flight are lost.

Configuration
REQ-030 SHALL, with macro ALU_STICKY_OVF_EN defined, set sticky_ovf on any pop whose out_flags[0] is 1 and clear it when clr_sticky is high at an edge; when both occur in the same cycle, set wins.
REQ-031 SHALL, without ALU_STICKY_OVF_EN, tie sticky_ovf to 0 and ignore clr_sticky.

Verification
REQ-032 SHALL verify reset: rst_n low for 2 cycles with in_valid high -> count = 0, out_valid = 0, status_flags = 0000 after release.
REQ-033 SHALL verify ordering: push 0x00000005/0010, 0xFFFFFFFF/1000, 0x80000000/1011 with out_ready low, then drain -> same three values in order; status_flags ends 1011.
REQ-034 SHALL verify full: DEPTH = 4, push 5 entries with out_ready low -> in_ready low after 4th; 5th value not stored; count = 4.
REQ-035 SHALL verify NOP drop and concurrent push/pop: push in_ctrl = 000 -> count unchanged; count = 2 with push and pop in one cycle -> count stays 2, order preserved.
REQ-036 SHALL verify sticky overflow: with ALU_STICKY_OVF_EN, pop flags 0001 -> sticky_ovf = 1; clr_sticky high for 1 cycle -> 0; simultaneous set and clear -> 1; without macro -> always 0.
REQ-037 SHALL verify mid-operation reset: rst_n low with count = 3 and a pop pending -> count = 0, no pop recorded in status_flags.
